// File: rtl/term_loopback_switch_matrix_if.sv
// rtl/term_loopback_switch_matrix_if.sv - wire groups and serial config port of the terminal switch matrix
interface term_loopback_switch_matrix_if #(
  parameter int N1W = 4,
  parameter int N2W = 8,
  parameter int N4W = 16
);
  logic [N1W-1:0] S1END;
  logic [N2W-1:0] S2MID;
  logic [N2W-1:0] S2END;
  logic [N4W-1:0] S4END;
  logic [N1W-1:0] N1BEG;
  logic [N2W-1:0] N2BEG;
  logic [N2W-1:0] N2BEGb;
  logic [N4W-1:0] N4BEG;
  logic           Co0;
  logic           cfg_valid;
  logic           cfg_data;
  logic           cfg_last;
  logic           cfg_done;
  logic           cfg_err;

  modport master (
    output S1END, S2MID, S2END, S4END, cfg_valid, cfg_data, cfg_last,
    input  N1BEG, N2BEG, N2BEGb, N4BEG, Co0, cfg_done, cfg_err
  );

  modport slave (
    input  S1END, S2MID, S2END, S4END, cfg_valid, cfg_data, cfg_last,
    output N1BEG, N2BEG, N2BEGb, N4BEG, Co0, cfg_done, cfg_err
  );
endinterface

// File: rtl/term_loopback_switch_matrix.sv
// rtl/term_loopback_switch_matrix.sv - fabric-edge loopback matrix with per-group modes and serial config
module term_loopback_switch_matrix #(
  parameter int N1W      = 4,
  parameter int N2W      = 8,
  parameter int N4W      = 16,
  parameter int CFG_BITS = 9
) (
  input logic                         UserCLK,
  input logic                         Rst,
  term_loopback_switch_matrix_if.slave bus
);

  if (CFG_BITS != 9) begin : g_bad_cfg_bits
    $error("CFG_BITS must be 9");
  end

  typedef enum logic [1:0] {
    MODE_REFLECT  = 2'b00,
    MODE_STRAIGHT = 2'b01,
    MODE_TIE_LOW  = 2'b10,
    MODE_REG_REFL = 2'b11
  } mode_e;

  logic [8:0]     shreg_q, shreg_d;
  logic [8:0]     active_q, active_d;
  logic [3:0]     count_q, count_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [8:0]     shreg_next;

  logic [N1W-1:0] rev1, r1_q;
  logic [N2W-1:0] rev2m, r2m_q;
  logic [N2W-1:0] rev2e, r2e_q;
  logic [N4W-1:0] rev4, r4_q;

  mode_e          mode_g0, mode_g1, mode_g2, mode_g3;

  assign mode_g0 = mode_e'(active_q[8:7]);
  assign mode_g1 = mode_e'(active_q[6:5]);
  assign mode_g2 = mode_e'(active_q[4:3]);
  assign mode_g3 = mode_e'(active_q[2:1]);

  always_comb begin
    rev1  = '0;
    rev2m = '0;
    rev2e = '0;
    rev4  = '0;
    for (int i = 0; i < N1W; i++) rev1[i]  = bus.S1END[N1W-1-i];
    for (int i = 0; i < N2W; i++) rev2m[i] = bus.S2MID[N2W-1-i];
    for (int i = 0; i < N2W; i++) rev2e[i] = bus.S2END[N2W-1-i];
    for (int i = 0; i < N4W; i++) rev4[i]  = bus.S4END[N4W-1-i];
  end

  always_comb begin
    bus.N1BEG = '0;
    case (mode_g0)
      MODE_REFLECT:  bus.N1BEG = rev1;
      MODE_STRAIGHT: bus.N1BEG = bus.S1END;
      MODE_TIE_LOW:  bus.N1BEG = '0;
      default:       bus.N1BEG = r1_q;
    endcase
    bus.N2BEG = '0;
    case (mode_g1)
      MODE_REFLECT:  bus.N2BEG = rev2m;
      MODE_STRAIGHT: bus.N2BEG = bus.S2MID;
      MODE_TIE_LOW:  bus.N2BEG = '0;
      default:       bus.N2BEG = r2m_q;
    endcase
    bus.N2BEGb = '0;
    case (mode_g2)
      MODE_REFLECT:  bus.N2BEGb = rev2e;
      MODE_STRAIGHT: bus.N2BEGb = bus.S2END;
      MODE_TIE_LOW:  bus.N2BEGb = '0;
      default:       bus.N2BEGb = r2e_q;
    endcase
    bus.N4BEG = '0;
    case (mode_g3)
      MODE_REFLECT:  bus.N4BEG = rev4;
      MODE_STRAIGHT: bus.N4BEG = bus.S4END;
      MODE_TIE_LOW:  bus.N4BEG = '0;
      default:       bus.N4BEG = r4_q;
    endcase
  end

  assign bus.Co0      = active_q[0];
  assign bus.cfg_done = done_q;
  assign bus.cfg_err  = err_q;

  // The commit word includes the bit arriving with cfg_last, so compare against count 8.
  assign shreg_next = {shreg_q[7:0], bus.cfg_data};

  always_comb begin
    shreg_d  = shreg_q;
    active_d = active_q;
    count_d  = count_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (bus.cfg_valid) begin
      shreg_d = shreg_next;
      if (bus.cfg_last) begin
        count_d = 4'd0;
        if (count_q == 4'd8) begin
          active_d = shreg_next;
          done_d   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (count_q != 4'd10) begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge UserCLK or posedge Rst) begin
    if (Rst) begin
      shreg_q  <= '0;
      active_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      r1_q     <= '0;
      r2m_q    <= '0;
      r2e_q    <= '0;
      r4_q     <= '0;
    end else begin
      shreg_q  <= shreg_d;
      active_q <= active_d;
      count_q  <= count_d;
      done_q   <= done_d;
      err_q    <= err_d;
      r1_q     <= rev1;
      r2m_q    <= rev2m;
      r2e_q    <= rev2e;
      r4_q     <= rev4;
    end
  end

endmodule
